bht_table: RTL and testbench
============================

# bht_table

Branch history and target table storing the 2-bit saturating token and 32-bit target that the MEM stage computes for each branch or jump. It sits between IF and MEM. MEM is the writer and the block is the responder: it answers IF-stage lookups with a registered prediction, carried down the pipeline as `bht_token`. Valid bits are cleared by a post-reset sweep FSM, so the table RAM itself needs no reset.

## Interface
- IDX_W, 10, index width; table holds 2^IDX_W entries, indexed by pc[IDX_W+1:2]
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- fetch_pc  in  32  IF-stage PC to look up
- fetch_hold  in  1  pipeline stall; freezes the output registers
- pred_valid  out  1  outputs correspond to a looked-up PC
- pred_token  out  2  stored 2-bit counter (00 if entry invalid)
- pred_taken  out  1  pred_token[1] & entry valid
- pred_pc  out  32  predicted next PC: target if pred_taken, else looked-up PC + 4
- ready  out  1  init sweep complete; IF must not fetch while 0
- bht_write_addr  in  IDX_W  entry index from MEM (pc[IDX_W+1:2])
- bht_we  in  1  write strobe
- bht_din  in  34  {token[1:0], target[31:0]}

## Operation
- Storage per entry: valid (1b, in a separate array), token (2b), target (32b). Token and target storage has no reset.
- FSM states: INIT, RUN.
  - rst forces INIT with the sweep counter at 0.
  - INIT clears valid[counter] each cycle and increments the counter.
  - INIT goes to RUN after clearing entry 2^IDX_W-1.
  - RUN holds until rst.
- Writes in RUN: if bht_we, entry[bht_write_addr] <= {valid=1, bht_din}.
  - MEM may hold bht_we high for several cycles during a cache stall with identical data. Repeated writes are idempotent, and no edge detection is done.
- Writes in INIT are ignored.
- Lookups in RUN with fetch_hold=0: index fetch_pc and register all prediction outputs.
  - pred_pc = taken ? target : fetch_pc+4, with 32-bit wrap (FFFFFFFC+4 = 00000000).
  - An invalid entry returns token 00, taken 0, pc+4.
- fetch_hold=1: pred_* hold their values. Writes still proceed.
- In INIT: pred_valid=0, and the pred_* registers keep their reset values.
- Same-cycle write and lookup to the same index: behaviour depends on the macro (see Configuration).

## Timing
- Reset values: pred_valid 0, pred_token 00, pred_taken 0, pred_pc 0, ready 0.
- INIT sweep length:
  - ready rises at the 2^IDX_W-th rising edge after the first edge with rst=0.
  - With IDX_W=10 that is 1024 cycles.
  - ready is registered and drops on the edge where rst is sampled high.
- Lookup latency is 1 cycle: fetch_pc presented at edge N, results visible after edge N.
- Write latency is 1 cycle: a write at edge N is visible to a lookup at edge N+1 regardless of the macro.
- rst mid-operation or mid-sweep:
  - Sweep restarts from 0 and all valid bits are re-cleared.
  - Any write in the same cycle as rst is dropped.

## Configuration
- BHT_BYPASS_EN defined: a lookup whose index equals bht_write_addr while bht_we=1 (in RUN) returns the incoming data, i.e. token=bht_din[33:32], valid=1, and target=bht_din[31:0] if taken.
- BHT_BYPASS_EN undefined: read-first; such a lookup returns the entry's previous contents.

## Test plan
- Reset sweep:
  - Stimulus: rst 1 for 3 cycles, then 0.
  - Required: ready=0 for exactly 1023 edges and 1 from the 1024th edge; pred_valid=0 throughout.
- Cold lookup:
  - Stimulus: after ready, fetch_pc=0x00400010.
  - Required: next cycle pred_valid=1, token=00, taken=0, pred_pc=0x00400014.
- Write then read:
  - Stimulus: bht_we=1, addr=0x004, din={2'b10, 0x00400100}; next cycle fetch_pc=0x00000010.
  - Required: token=10, taken=1, pred_pc=0x00400100.
- Collision:
  - Stimulus: same-cycle write {11, 0x00000200} to index 0x004 and lookup of 0x00000010, with the old entry {01, 0x00000300}.
  - Required with macro: 11 / 0x00000200. Required without macro: 01, taken=0, pred_pc=0x00000014.
- Hold:
  - Stimulus: fetch_hold=1 for 4 cycles while fetch_pc changes.
  - Required: pred_* unchanged; a write during hold is visible after hold releases.
- Reset mid-sweep and mid-run:
  - Stimulus: rst at sweep count 500, and again after writes in RUN.
  - Required: ready=0 for 1024 cycles after release; previously written entries now read token 00, taken 0.

Source files
------------

// File: rtl/bht_table_if.sv
// Branch history table bus: IF lookup, prediction return and MEM write.
// master = pipeline side (IF/MEM), slave = bht_table.
interface bht_table_if #(
    parameter int IDX_W = 10
);
    logic [31:0]      fetch_pc;
    logic             fetch_hold;
    logic             pred_valid;
    logic [1:0]       pred_token;
    logic             pred_taken;
    logic [31:0]      pred_pc;
    logic             ready;
    logic [IDX_W-1:0] bht_write_addr;
    logic             bht_we;
    logic [33:0]      bht_din;

    modport master (
        output fetch_pc, fetch_hold,
        output bht_write_addr, bht_we, bht_din,
        input  pred_valid, pred_token, pred_taken,
        input  pred_pc, ready
    );

    modport slave (
        input  fetch_pc, fetch_hold,
        input  bht_write_addr, bht_we, bht_din,
        output pred_valid, pred_token, pred_taken,
        output pred_pc, ready
    );
endinterface

// File: rtl/bht_table.sv
// Branch history/target table: 2-bit token + 32-bit target per entry,
// registered lookup for IF, writes from MEM, valid bits cleared by an
// INIT sweep after reset. Ports: clk, rst (sync, active-high), bus
// (bht_table_if.slave). Optional macro BHT_BYPASS_EN forwards a
// same-cycle write to a colliding lookup; default is read-first.
module bht_table #(
    parameter int IDX_W = 10
) (
    input  logic         clk,
    input  logic         rst,
    bht_table_if.slave   bus
);
    localparam int N = 2 ** IDX_W;

    typedef enum logic {
        INIT,
        RUN
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] sweep_cnt;

    logic [N-1:0]     valid_q;
    logic [1:0]       tok_mem [N];
    logic [31:0]      tgt_mem [N];

    logic [IDX_W-1:0] rd_idx;
    logic             rd_valid;
    logic [1:0]       rd_tok;
    logic [31:0]      rd_tgt;
    logic [1:0]       lk_tok;
    logic             lk_taken;
    logic [31:0]      lk_pc;
    logic             wr_en;

    assign wr_en = (state == RUN) && bus.bht_we;

    always_comb begin
        rd_idx   = bus.fetch_pc[IDX_W+1:2];
        rd_valid = valid_q[rd_idx];
        rd_tok   = tok_mem[rd_idx];
        rd_tgt   = tgt_mem[rd_idx];
`ifdef BHT_BYPASS_EN
        if (wr_en && (bus.bht_write_addr == rd_idx)) begin
            rd_valid = 1'b1;
            rd_tok   = bus.bht_din[33:32];
            rd_tgt   = bus.bht_din[31:0];
        end
`endif
        lk_tok   = rd_valid ? rd_tok : 2'b00;
        lk_taken = lk_tok[1];
        lk_pc    = lk_taken ? rd_tgt : bus.fetch_pc + 32'd4;
    end

    // Token/target storage carries no reset; valid_q gates it.
    always_ff @(posedge clk) begin
        if (!rst && wr_en) begin
            tok_mem[bus.bht_write_addr] <= bus.bht_din[33:32];
            tgt_mem[bus.bht_write_addr] <= bus.bht_din[31:0];
        end
    end

    // Valid bits are cleared by the sweep rather than by rst.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == INIT) begin
                valid_q[sweep_cnt] <= 1'b0;
            end else if (bus.bht_we) begin
                valid_q[bus.bht_write_addr] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= INIT;
            sweep_cnt      <= '0;
            bus.ready      <= 1'b0;
            bus.pred_valid <= 1'b0;
            bus.pred_token <= 2'b00;
            bus.pred_taken <= 1'b0;
            bus.pred_pc    <= 32'd0;
        end else begin
            unique case (state)
                INIT: begin
                    sweep_cnt <= sweep_cnt + 1'b1;
                    if (sweep_cnt == IDX_W'(N - 1)) begin
                        state     <= RUN;
                        bus.ready <= 1'b1;
                    end
                end
                RUN: begin
                    if (!bus.fetch_hold) begin
                        bus.pred_valid <= 1'b1;
                        bus.pred_token <= lk_tok;
                        bus.pred_taken <= lk_taken;
                        bus.pred_pc    <= lk_pc;
                    end
                end
                default: state <= INIT;
            endcase
        end
    end
endmodule

// File: tb/tb_bht_table.sv
// Directed self-checking bench for bht_table.
// Build with or without +define+BHT_BYPASS_EN.
module tb_bht_table;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    bht_table_if #(.IDX_W(10)) bus ();

    bht_table #(.IDX_W(10)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_pred(input string tag, input logic v,
                            input logic [1:0] tok, input logic tk,
                            input logic [31:0] pc);
        chk({tag, "_valid"}, 32'(bus.pred_valid), 32'(v));
        chk({tag, "_token"}, 32'(bus.pred_token), 32'(tok));
        chk({tag, "_taken"}, 32'(bus.pred_taken), 32'(tk));
        chk({tag, "_pc"},    bus.pred_pc,         pc);
    endtask

    // ready must stay low for 1023 edges and rise on the 1024th.
    task automatic sweep(input string tag);
        for (int i = 1; i <= 1024; i++) begin
            step();
            chk({tag, "_ready"}, 32'(bus.ready), 32'(i == 1024));
            chk({tag, "_pvalid"}, 32'(bus.pred_valid), 32'd0);
        end
    endtask

    task automatic wr(input logic [9:0] a, input logic [33:0] d);
        bus.bht_we         = 1'b1;
        bus.bht_write_addr = a;
        bus.bht_din        = d;
    endtask

    initial begin
        rst                = 1'b1;
        bus.fetch_pc       = 32'd0;
        bus.fetch_hold     = 1'b0;
        bus.bht_we         = 1'b0;
        bus.bht_write_addr = '0;
        bus.bht_din        = '0;

        repeat (3) step();
        chk("rst_ready", 32'(bus.ready), 32'd0);
        chk_pred("rst", 1'b0, 2'b00, 1'b0, 32'd0);

        rst = 1'b0;
        sweep("sweep1");
        chk_pred("init_hold", 1'b0, 2'b00, 1'b0, 32'd0);

        // cold lookup
        bus.fetch_pc = 32'h0040_0010;
        step();
        chk_pred("cold", 1'b1, 2'b00, 1'b0, 32'h0040_0014);

        // write idx 4, lookup elsewhere meanwhile
        bus.fetch_pc = 32'h0000_0020;
        wr(10'h004, {2'b10, 32'h0040_0100});
        step();
        bus.bht_we   = 1'b0;
        bus.fetch_pc = 32'h0000_0010;
        step();
        chk_pred("wr_rd", 1'b1, 2'b10, 1'b1, 32'h0040_0100);

        // 32-bit wrap on invalid top entry
        bus.fetch_pc = 32'hFFFF_FFFC;
        step();
        chk_pred("wrap", 1'b1, 2'b00, 1'b0, 32'h0000_0000);

        // collision: old entry {01, 0x300}
        bus.fetch_pc = 32'h0000_0020;
        wr(10'h004, {2'b01, 32'h0000_0300});
        step();
        wr(10'h004, {2'b11, 32'h0000_0200});
        bus.fetch_pc = 32'h0000_0010;
        step();
`ifdef BHT_BYPASS_EN
        chk_pred("coll", 1'b1, 2'b11, 1'b1, 32'h0000_0200);
`else
        chk_pred("coll", 1'b1, 2'b01, 1'b0, 32'h0000_0014);
`endif
        bus.bht_we = 1'b0;
        step();
        chk_pred("coll_after", 1'b1, 2'b11, 1'b1, 32'h0000_0200);

        // hold: outputs frozen, write to idx 5 still lands
        bus.fetch_hold = 1'b1;
        wr(10'h005, {2'b10, 32'h0000_1000});
        for (int i = 0; i < 4; i++) begin
            bus.fetch_pc = 32'h0000_0040 << i;
            step();
            bus.bht_we = 1'b0;
            chk_pred("hold", 1'b1, 2'b11, 1'b1, 32'h0000_0200);
        end
        bus.fetch_hold = 1'b0;
        bus.fetch_pc   = 32'h0000_0014;
        step();
        chk_pred("hold_rel", 1'b1, 2'b10, 1'b1, 32'h0000_1000);

        // reset mid-run
        rst = 1'b1;
        step();
        chk("rst2_ready", 32'(bus.ready), 32'd0);
        chk_pred("rst2", 1'b0, 2'b00, 1'b0, 32'd0);
        rst = 1'b0;

        // reset at sweep count 500, with an ignored INIT write
        repeat (500) step();
        wr(10'h007, {2'b11, 32'h0000_7000});
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (20) step();
        bus.bht_we = 1'b0;
        chk("mid_ready", 32'(bus.ready), 32'd0);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        sweep("sweep2");

        bus.fetch_pc = 32'h0000_0010;
        step();
        chk_pred("post_rst4", 1'b1, 2'b00, 1'b0, 32'h0000_0014);
        bus.fetch_pc = 32'h0000_0014;
        step();
        chk_pred("post_rst5", 1'b1, 2'b00, 1'b0, 32'h0000_0018);

        // INIT write during a fresh sweep must be ignored
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (500) step();
        wr(10'h007, {2'b11, 32'h0000_7000});
        step();
        bus.bht_we = 1'b0;
        repeat (523) step();
        chk("sweep3_ready", 32'(bus.ready), 32'd1);
        bus.fetch_pc = 32'h0000_001C;
        step();
        chk_pred("init_wr", 1'b1, 2'b00, 1'b0, 32'h0000_0020);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
